// File: rtl/hazard_if.sv
// Pipeline hazard interface: decode/EX/MEM feedback into the hazard
// controller and its freeze, bubble, redirect and statistics outputs.
interface hazard_if #(
  parameter int CNT_W = 16
);
  // Decode-stage source operands
  logic [4:0]       de_rs1;
  logic [4:0]       de_rs2;
  logic             de_uses_rs1;
  logic             de_uses_rs2;
  // EX-stage instruction
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             br_taken;
  logic [31:0]      br_target;
  // Data memory back-pressure
  logic             mem_busy;
  // Controller outputs
  logic             stall_fd;
  logic             bubble_ex;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: supplies stage information, consumes control
  modport master (
    output de_rs1, de_rs2, de_uses_rs1, de_uses_rs2,
    output ex_rd, ex_is_load, br_taken, br_target, mem_busy,
    input  stall_fd, bubble_ex, redirect_valid, redirect_pc,
    input  state, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  de_rs1, de_rs2, de_uses_rs1, de_uses_rs2,
    input  ex_rd, ex_is_load, br_taken, br_target, mem_busy,
    output stall_fd, bubble_ex, redirect_valid, redirect_pc,
    output state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the RV32I core.
// Detects load-use hazards, freezes fetch/decode, inserts EX bubbles,
// issues the fetch redirect after taken control transfers and keeps
// saturating stall/flush statistics. FSM: RUN / FLUSH / MEM_WAIT.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,  // redirect bubbles after the branch cycle, 1..15
  parameter int CNT_W        = 16  // statistics counter width
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // fl_cnt counts down remaining FLUSH cycles; last one is fl_cnt==0
  localparam logic [3:0] FL_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;      // state to resume after MEM_WAIT
  logic [3:0]       fl_q, fl_d;
  logic             hazard;
  logic             stall_fd;
  logic             bubble_ex;
  logic             redirect_set;      // branch accepted this cycle
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // State register with synchronous reset; a reset always returns to RUN
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      fl_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fl_q    <= fl_d;
    end
  end

  // Next-state logic: mem_busy dominates, then taken branch, flush countdown
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    fl_d         = fl_q;
    redirect_set = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.mem_busy) begin
          state_d = MEM_WAIT;
          ret_d   = RUN;
        end else if (hz.br_taken) begin
          state_d      = FLUSH;
          fl_d         = FL_LOAD;
          redirect_set = 1'b1;
        end
      end
      FLUSH: begin
        if (hz.mem_busy) begin
          // fl_cnt is left untouched so the flush resumes where it stopped
          state_d = MEM_WAIT;
          ret_d   = FLUSH;
        end else if (fl_q == 4'd0) begin
          state_d = RUN;
        end else begin
          fl_d = fl_q - 4'd1;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_busy) begin
          state_d = ret_q;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output logic: combinational freeze and bubble from current state and inputs
  always_comb begin
    hazard = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
             ((hz.de_uses_rs1 && (hz.de_rs1 == hz.ex_rd)) ||
              (hz.de_uses_rs2 && (hz.de_rs2 == hz.ex_rd)));
    stall_fd  = hz.mem_busy || ((state_q == RUN) && hazard);
    bubble_ex = !hz.mem_busy &&
                (((state_q == RUN) && (hazard || hz.br_taken)) ||
                 (state_q == FLUSH));
  end

  // Redirect register: one-cycle pulse on the edge that accepts a branch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      redirect_valid_q <= redirect_set;
      if (redirect_set) begin
        redirect_pc_q <= hz.br_target;
      end
    end
  end

  // Statistics counters: count stall/bubble cycles, stick at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_fd && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (bubble_ex && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign hz.stall_fd       = stall_fd;
  assign hz.bubble_ex      = bubble_ex;
  assign hz.redirect_valid = redirect_valid_q;
  assign hz.redirect_pc    = redirect_pc_q;
  assign hz.state          = state_q;
  assign hz.stall_cnt      = stall_cnt_q;
  assign hz.flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share one stimulus:
// A uses FLUSH_CYCLES=2/CNT_W=16, B uses FLUSH_CYCLES=3/CNT_W=4 (saturation).
// Expected values come from a cycle model that tracks "flush bubbles still
// owed" and a "waiting on memory" flag rather than the RTL encoding.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  de_rs1, de_rs2, ex_rd;
  logic        de_uses_rs1, de_uses_rs2, ex_is_load, br_taken, mem_busy;
  logic [31:0] br_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(16)) hif_a ();
  hazard_if #(.CNT_W(4))  hif_b ();

  assign hif_a.de_rs1      = de_rs1;
  assign hif_a.de_rs2      = de_rs2;
  assign hif_a.de_uses_rs1 = de_uses_rs1;
  assign hif_a.de_uses_rs2 = de_uses_rs2;
  assign hif_a.ex_rd       = ex_rd;
  assign hif_a.ex_is_load  = ex_is_load;
  assign hif_a.br_taken    = br_taken;
  assign hif_a.br_target   = br_target;
  assign hif_a.mem_busy    = mem_busy;
  assign hif_b.de_rs1      = de_rs1;
  assign hif_b.de_rs2      = de_rs2;
  assign hif_b.de_uses_rs1 = de_uses_rs1;
  assign hif_b.de_uses_rs2 = de_uses_rs2;
  assign hif_b.ex_rd       = ex_rd;
  assign hif_b.ex_is_load  = ex_is_load;
  assign hif_b.br_taken    = br_taken;
  assign hif_b.br_target   = br_target;
  assign hif_b.mem_busy    = mem_busy;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .hz(hif_a.slave));
  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .hz(hif_b.slave));

  // ---------------- reference model ----------------
  typedef struct {
    int          owed;     // FLUSH bubbles still to issue
    bit          in_wait;  // frozen on memory
    bit          rv;
    logic [31:0] rpc;
    int          scnt;
    int          fcnt;
  } mdl_t;

  mdl_t m [2];
  int   fc   [2] = '{2, 3};
  int   cmax [2] = '{65535, 15};

  function automatic bit m_hazard();
    return ex_is_load && (ex_rd != 0) &&
           ((de_uses_rs1 && de_rs1 == ex_rd) || (de_uses_rs2 && de_rs2 == ex_rd));
  endfunction

  function automatic int m_state(int k);
    if (m[k].in_wait) return 2;
    if (m[k].owed > 0) return 1;
    return 0;
  endfunction

  function automatic bit m_stall(int k);
    return mem_busy || (m_state(k) == 0 && m_hazard());
  endfunction

  function automatic bit m_bubble(int k);
    int st;
    st = m_state(k);
    return !mem_busy && ((st == 0 && (m_hazard() || br_taken)) || st == 1);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m[k] = '{owed: 0, in_wait: 1'b0, rv: 1'b0, rpc: 32'd0, scnt: 0, fcnt: 0};
      end else begin
        int st;
        bit s, b;
        st = m_state(k);
        s  = m_stall(k);
        b  = m_bubble(k);
        if (s && m[k].scnt < cmax[k]) m[k].scnt++;
        if (b && m[k].fcnt < cmax[k]) m[k].fcnt++;
        m[k].rv = (st == 0) && br_taken && !mem_busy;
        if (m[k].rv) m[k].rpc = br_target;
        if (st == 2) begin
          if (!mem_busy) m[k].in_wait = 1'b0;
        end else if (mem_busy) begin
          m[k].in_wait = 1'b1;
        end else if (st == 0 && br_taken) begin
          m[k].owed = fc[k];
        end else if (st == 1) begin
          m[k].owed--;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, " a.stall_fd"},  32'(hif_a.stall_fd),       32'(m_stall(0)));
    check({tag, " a.bubble_ex"}, 32'(hif_a.bubble_ex),      32'(m_bubble(0)));
    check({tag, " a.rv"},        32'(hif_a.redirect_valid), 32'(m[0].rv));
    check({tag, " a.rpc"},       hif_a.redirect_pc,         m[0].rpc);
    check({tag, " a.state"},     32'(hif_a.state),          32'(m_state(0)));
    check({tag, " a.stall_cnt"}, 32'(hif_a.stall_cnt),      32'(m[0].scnt));
    check({tag, " a.flush_cnt"}, 32'(hif_a.flush_cnt),      32'(m[0].fcnt));
    check({tag, " b.stall_fd"},  32'(hif_b.stall_fd),       32'(m_stall(1)));
    check({tag, " b.bubble_ex"}, 32'(hif_b.bubble_ex),      32'(m_bubble(1)));
    check({tag, " b.rv"},        32'(hif_b.redirect_valid), 32'(m[1].rv));
    check({tag, " b.rpc"},       hif_b.redirect_pc,         m[1].rpc);
    check({tag, " b.state"},     32'(hif_b.state),          32'(m_state(1)));
    check({tag, " b.stall_cnt"}, 32'(hif_b.stall_cnt),      32'(m[1].scnt));
    check({tag, " b.flush_cnt"}, 32'(hif_b.flush_cnt),      32'(m[1].fcnt));
  endtask

  // One clock: check at the falling edge, advance model at the rising edge
  task automatic cyc(string tag, bit do_chk = 1'b1);
    @(negedge clk);
    if (do_chk) check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    de_rs1 = 5'd0; de_rs2 = 5'd0; de_uses_rs1 = 1'b0; de_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc("reset");
    rst_n = 1'b1;
  endtask

  task automatic load_use(logic [4:0] rd);
    ex_is_load = 1'b1; ex_rd = rd; de_rs1 = rd; de_uses_rs1 = 1'b1;
  endtask

  initial begin
    // Power-up reset: DUT state is unknown before the first edge
    idle();
    rst_n = 1'b0;
    cyc("por", 1'b0);
    rst_n = 1'b1;
    cyc("after_reset");

    // Load-use on x5: one stall + one bubble, stays in RUN
    do_reset();
    load_use(5'd5);
    cyc("loaduse");
    idle();
    cyc("loaduse_after");
    check("loaduse a.stall_cnt==1", 32'(hif_a.stall_cnt), 32'd1);
    check("loaduse a.flush_cnt==1", 32'(hif_a.flush_cnt), 32'd1);

    // Load to x0 never hazards; also rs2 path
    do_reset();
    load_use(5'd0);
    cyc("x0");
    idle();
    ex_is_load = 1'b1; ex_rd = 5'd9; de_rs2 = 5'd9; de_uses_rs2 = 1'b1;
    cyc("rs2_hazard");
    de_uses_rs2 = 1'b0;
    cyc("rs2_unused");
    idle();

    // Taken branch to 0x100
    do_reset();
    br_taken = 1'b1; br_target = 32'h0000_0100;
    cyc("br_T");
    idle();
    for (int i = 0; i < 4; i++) cyc("br_flush");
    check("br a.flush_cnt==3", 32'(hif_a.flush_cnt), 32'd3);

    // Branch, then memory stall in the middle of the flush
    do_reset();
    br_taken = 1'b1; br_target = 32'h0000_0200;
    cyc("brmem_T");
    idle();
    cyc("brmem_T1");
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cyc("brmem_busy");
    mem_busy = 1'b0;
    for (int i = 0; i < 5; i++) cyc("brmem_resume");
    check("brmem b.flush_cnt==4", 32'(hif_b.flush_cnt), 32'd4);
    check("brmem b.stall_cnt==3", 32'(hif_b.stall_cnt), 32'd3);

    // mem_busy + branch + hazard together, then memory releases
    do_reset();
    mem_busy = 1'b1; br_taken = 1'b1; br_target = 32'hdead_beef; load_use(5'd7);
    for (int i = 0; i < 2; i++) cyc("prio_busy");
    mem_busy = 1'b0; ex_is_load = 1'b0; de_uses_rs1 = 1'b0;
    cyc("prio_exit");
    cyc("prio_branch");
    br_taken = 1'b0;
    for (int i = 0; i < 5; i++) cyc("prio_flush");
    check("prio a.stall_cnt==2", 32'(hif_a.stall_cnt), 32'd2);

    // Reset during FLUSH, then stall-counter saturation on B
    do_reset();
    br_taken = 1'b1; br_target = 32'h0000_0400;
    cyc("rstfl_T");
    idle();
    cyc("rstfl_flush");
    rst_n = 1'b0;
    cyc("rstfl_reset");
    rst_n = 1'b1;
    cyc("rstfl_after");
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) cyc("sat_busy");
    mem_busy = 1'b0;
    cyc("sat_after");
    check("sat b.stall_cnt==15", 32'(hif_b.stall_cnt), 32'd15);
    check("sat a.stall_cnt==20", 32'(hif_a.stall_cnt), 32'd20);

    // Random traffic with small register indices so hazards are frequent
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      de_rs1      = 5'($urandom_range(0, 3));
      de_rs2      = 5'($urandom_range(0, 3));
      de_uses_rs1 = 1'($urandom_range(0, 1));
      de_uses_rs2 = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_is_load  = ($urandom_range(0, 2) == 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      br_target   = $urandom;
      mem_busy    = ($urandom_range(0, 4) == 0);
      rst_n       = ($urandom_range(0, 99) != 0);
      cyc("rand");
    end
    rst_n = 1'b1;
    idle();
    cyc("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
